// File: rtl/dm_rmw_ctrl.sv
// dm_rmw_ctrl: MEM-stage sequencer for a synchronous word-wide data memory.
// Handles word and byte loads/stores. A byte store is a read-modify-write:
// the word is read, one byte lane is replaced, and the merged word is written.
// Every externally visible output comes straight from a flop.

module dm_rmw_ctrl #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_i,
    input  logic          we_i,
    input  logic          sb_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o,
    output logic [31:0]   rdata_o,
    output logic [AW-3:0] dm_addr_o,
    output logic          dm_we_o,
    output logic [31:0]   dm_wdata_o,
    input  logic [31:0]   dm_rdata_i
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_MRG  = 3'd2,
        S_WR   = 3'd3,
        S_FIN  = 3'd4
    } state_e;

    // Replace byte lane 'lane' of 'word' with 'b'.
    function automatic logic [31:0] merge_byte(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [7:0]  b);
        logic [31:0] r;
        r = word;
        case (lane)
            2'b00:   r[7:0]   = b;
            2'b01:   r[15:8]  = b;
            2'b10:   r[23:16] = b;
            2'b11:   r[31:24] = b;
            default: r        = word;
        endcase
        return r;
    endfunction

    // Extract byte lane 'lane' of 'word' and sign-extend it to 32 bits.
    function automatic logic [31:0] sext_byte(input logic [31:0] word,
                                              input logic [1:0]  lane);
        logic [7:0] b;
        case (lane)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            2'b11:   b = word[31:24];
            default: b = 8'h00;
        endcase
        return {{24{b[7]}}, b};
    endfunction

    state_e        state_q,   state_d;
    logic          we_q,      we_d;
    logic          sb_q,      sb_d;
    logic [AW-1:0] addr_q,    addr_d;
    logic [7:0]    wbyte_q,   wbyte_d;     // store byte for the merge step
    logic [31:0]   wr_data_q, wr_data_d;   // word presented to memory in WR
    logic [31:0]   rdata_q,   rdata_d;
    logic          mis_q,     mis_d;       // current access is a misaligned word
    logic          busy_q,    busy_d;
    logic          done_q,    done_d;
    logic          err_q,     err_d;
    logic          dm_we_q,   dm_we_d;

    // Next-state, latch and datapath logic; output flops are loaded from the
    // next state so that each output matches the state it belongs to.
    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        sb_d      = sb_q;
        addr_d    = addr_q;
        wbyte_d   = wbyte_q;
        wr_data_d = wr_data_q;
        rdata_d   = rdata_q;
        mis_d     = mis_q;

        case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    we_d    = we_i;
                    sb_d    = sb_i;
                    addr_d  = addr_i;
                    wbyte_d = wdata_i[7:0];
                    if (!sb_i && (addr_i[1:0] != 2'b00)) begin
                        // Misaligned word: no memory traffic, report and finish.
                        mis_d   = 1'b1;
                        state_d = S_FIN;
                    end else if (we_i && !sb_i) begin
                        mis_d     = 1'b0;
                        wr_data_d = wdata_i;
                        state_d   = S_WR;
                    end else begin
                        mis_d   = 1'b0;
                        state_d = S_RD;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD: begin
                state_d = S_MRG;
            end
            S_MRG: begin
                if (we_q) begin
                    wr_data_d = merge_byte(dm_rdata_i, addr_q[1:0], wbyte_q);
                    state_d   = S_WR;
                end else begin
                    if (sb_q) begin
                        rdata_d = sext_byte(dm_rdata_i, addr_q[1:0]);
                    end else begin
                        rdata_d = dm_rdata_i;
                    end
                    state_d = S_FIN;
                end
            end
            S_WR: begin
                state_d = S_FIN;
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d  = (state_d != S_IDLE);
        dm_we_d = (state_d == S_WR);
        done_d  = (state_d == S_FIN);
        err_d   = (state_d == S_FIN) && mis_d;
    end

    // State, latched request and registered outputs; reset aborts any access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            we_q      <= 1'b0;
            sb_q      <= 1'b0;
            addr_q    <= '0;
            wbyte_q   <= 8'h00;
            wr_data_q <= 32'h0000_0000;
            rdata_q   <= 32'h0000_0000;
            mis_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            dm_we_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            sb_q      <= sb_d;
            addr_q    <= addr_d;
            wbyte_q   <= wbyte_d;
            wr_data_q <= wr_data_d;
            rdata_q   <= rdata_d;
            mis_q     <= mis_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            dm_we_q   <= dm_we_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign rdata_o    = rdata_q;
    assign dm_we_o    = dm_we_q;
    assign dm_addr_o  = addr_q[AW-1:2];
    assign dm_wdata_o = wr_data_q;

endmodule

// File: tb/tb_dm_rmw_ctrl.sv
// Directed self-checking bench for dm_rmw_ctrl with a behavioural
// synchronous-read word memory attached to the memory port.

module tb_dm_rmw_ctrl;

    localparam int AW = 10;

    logic          clk;
    logic          rst_n;
    logic          req;
    logic          we;
    logic          sb;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic          busy;
    logic          done;
    logic          err;
    logic [31:0]   rdata;
    logic [AW-3:0] dm_addr;
    logic          dm_we;
    logic [31:0]   dm_wdata;
    logic [31:0]   dm_rdata;

    logic [31:0]   mem [0:(1<<(AW-2))-1];

    int n_vec;
    int n_err;

    // Results of the most recent access
    int          done_cyc;
    int          we_cyc;
    int          we_cnt;
    int          err_seen;
    logic [31:0] we_addr;

    dm_rmw_ctrl #(.AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (req),
        .we_i       (we),
        .sb_i       (sb),
        .addr_i     (addr),
        .wdata_i    (wdata),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err),
        .rdata_o    (rdata),
        .dm_addr_o  (dm_addr),
        .dm_we_o    (dm_we),
        .dm_wdata_o (dm_wdata),
        .dm_rdata_i (dm_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read, synchronous-write word memory
    always @(posedge clk) begin
        if (dm_we) mem[dm_addr] <= dm_wdata;
        dm_rdata <= mem[dm_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one access; record write/done cycles relative to the sampling edge.
    // With noise=1, req pulses to another address during cycles 1..3.
    task automatic run(input logic w, input logic s, input logic [AW-1:0] a,
                       input logic [31:0] d, input bit noise);
        @(negedge clk);
        req = 1'b1; we = w; sb = s; addr = a; wdata = d;
        @(posedge clk);
        #1;
        req = 1'b0; we = ~w; sb = ~s; addr = ~a; wdata = ~d;
        done_cyc = 0; we_cyc = 0; we_cnt = 0; err_seen = 0; we_addr = 32'h0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (dm_we) begin
                we_cnt++;
                we_cyc  = c;
                we_addr = {24'h0, dm_addr};
            end
            if (done && done_cyc == 0) begin
                done_cyc = c;
                err_seen = {31'h0, err};
            end
            if (noise) begin
                req = (c <= 3);
                we = 1'b1; sb = 1'b0; addr = 10'h040; wdata = 32'h0BAD0BAD;
            end
            if (done_cyc != 0) break;
        end
    endtask

    initial begin
        logic [31:0] lane_exp [4];
        logic [31:0] lb_exp   [4];
        int          done2;
        int          wes;
        logic [31:0] wa [2];
        logic [31:0] wc [2];

        n_vec = 0; n_err = 0;
        rst_n = 1'b0; req = 1'b0; we = 1'b0; sb = 1'b0; addr = '0; wdata = 32'h0;
        for (int i = 0; i < (1 << (AW - 2)); i++) mem[i] = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy",   {31'h0, busy},  32'h0);
        chk("rst_done",   {31'h0, done},  32'h0);
        chk("rst_err",    {31'h0, err},   32'h0);
        chk("rst_rdata",  rdata,          32'h0);
        chk("rst_dm_we",  {31'h0, dm_we}, 32'h0);
        chk("rst_dm_addr",{24'h0, dm_addr}, 32'h0);
        chk("rst_dm_wdata", dm_wdata,     32'h0);
        rst_n = 1'b1;

        // Word store then word load
        run(1'b1, 1'b0, 10'h004, 32'hDEADBEEF, 1'b0);
        chk("sw_we_cyc",   we_cyc,   1);
        chk("sw_we_cnt",   we_cnt,   1);
        chk("sw_we_addr",  we_addr,  32'h1);
        chk("sw_done_cyc", done_cyc, 2);
        chk("sw_err",      err_seen, 0);
        @(negedge clk);
        chk("sw_idle_busy", {31'h0, busy}, 32'h0);
        run(1'b0, 1'b0, 10'h004, 32'h0, 1'b0);
        chk("lw_done_cyc", done_cyc, 3);
        chk("lw_we_cnt",   we_cnt,   0);
        chk("lw_rdata",    rdata,    32'hDEADBEEF);

        // Byte store into every lane of 0x11223344
        lane_exp[0] = 32'h112233AA; lane_exp[1] = 32'h1122AA44;
        lane_exp[2] = 32'h11AA3344; lane_exp[3] = 32'hAA223344;
        for (int l = 0; l < 4; l++) begin
            run(1'b1, 1'b0, 10'h008, 32'h11223344, 1'b0);
            run(1'b1, 1'b1, 10'h008 + l[AW-1:0], 32'h123456AA, 1'b0);
            chk("sb_we_cyc",   we_cyc,   3);
            chk("sb_we_cnt",   we_cnt,   1);
            chk("sb_done_cyc", done_cyc, 4);
            run(1'b0, 1'b0, 10'h008, 32'h0, 1'b0);
            chk("sb_word", rdata, lane_exp[l]);
        end

        // Byte loads with sign extension
        lb_exp[0] = 32'h00000001; lb_exp[1] = 32'h0000007F;
        lb_exp[2] = 32'hFFFFFFFF; lb_exp[3] = 32'hFFFFFF80;
        run(1'b1, 1'b0, 10'h00C, 32'h80FF7F01, 1'b0);
        for (int l = 0; l < 4; l++) begin
            run(1'b0, 1'b1, 10'h00C + l[AW-1:0], 32'h0, 1'b0);
            chk("lb_done_cyc", done_cyc, 3);
            chk("lb_rdata",    rdata,    lb_exp[l]);
        end

        // Misaligned word store and load
        run(1'b1, 1'b0, 10'h006, 32'h01234567, 1'b0);
        chk("mis_sw_done", done_cyc, 1);
        chk("mis_sw_err",  err_seen, 1);
        chk("mis_sw_we",   we_cnt,   0);
        chk("mis_sw_rdata", rdata,   32'hFFFFFF80);
        run(1'b0, 1'b0, 10'h003, 32'h0, 1'b0);
        chk("mis_lw_done", done_cyc, 1);
        chk("mis_lw_err",  err_seen, 1);
        chk("mis_lw_rdata", rdata,   32'hFFFFFF80);
        run(1'b0, 1'b0, 10'h004, 32'h0, 1'b0);
        chk("mis_mem", rdata, 32'hDEADBEEF);
        chk("aligned_err", err_seen, 0);

        // Top word of the address space
        run(1'b1, 1'b0, 10'h3FC, 32'hCAFEF00D, 1'b0);
        chk("top_we_addr", we_addr, 32'hFF);
        run(1'b0, 1'b1, 10'h3FF, 32'h0, 1'b0);
        chk("top_lb", rdata, 32'hFFFFFFCA);
        run(1'b1, 1'b1, 10'h3FD, 32'h00000077, 1'b0);
        run(1'b0, 1'b0, 10'h3FC, 32'h0, 1'b0);
        chk("top_sb", rdata, 32'hCAFE770D);

        // req held high: second request taken only once back in IDLE
        @(negedge clk);
        req = 1'b1; we = 1'b1; sb = 1'b0; addr = 10'h010; wdata = 32'hA5A5A5A5;
        @(posedge clk);
        #1;
        addr = 10'h014; wdata = 32'h5A5A5A5A;
        done_cyc = 0; done2 = 0; wes = 0; wa[0] = 0; wa[1] = 0; wc[0] = 0; wc[1] = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (dm_we) begin
                if (wes < 2) begin
                    wa[wes] = {24'h0, dm_addr};
                    wc[wes] = c;
                end
                wes++;
            end
            if (done) begin
                if (done_cyc == 0) done_cyc = c;
                else done2 = c;
            end
            if (c == 4) req = 1'b0;
        end
        chk("hold_we_cnt", wes,      2);
        chk("hold_wa0",    wa[0],    32'h4);
        chk("hold_wc0",    wc[0],    32'h1);
        chk("hold_wa1",    wa[1],    32'h5);
        chk("hold_wc1",    wc[1],    32'h4);
        chk("hold_done1",  done_cyc, 2);
        chk("hold_done2",  done2,    5);
        run(1'b0, 1'b0, 10'h014, 32'h0, 1'b0);
        chk("hold_mem2", rdata, 32'h5A5A5A5A);

        // req pulses during a busy byte store are ignored
        run(1'b1, 1'b0, 10'h040, 32'h77777777, 1'b0);
        run(1'b1, 1'b1, 10'h020, 32'h000000EE, 1'b1);
        chk("noise_we_cnt", we_cnt, 1);
        chk("noise_done",   done_cyc, 4);
        repeat (3) @(negedge clk);
        chk("noise_idle", {31'h0, busy}, 32'h0);
        run(1'b0, 1'b0, 10'h040, 32'h0, 1'b0);
        chk("noise_mem", rdata, 32'h77777777);

        // Reset asserted in MRG of a byte store
        run(1'b1, 1'b0, 10'h018, 32'h55667788, 1'b0);
        @(negedge clk);
        req = 1'b1; we = 1'b1; sb = 1'b1; addr = 10'h019; wdata = 32'h000000EE;
        @(posedge clk);
        #1;
        req = 1'b0;
        @(negedge clk);             // cycle 1: RD
        @(negedge clk);             // cycle 2: MRG
        chk("mrg_busy", {31'h0, busy}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy",  {31'h0, busy},  32'h0);
        chk("arst_dm_we", {31'h0, dm_we}, 32'h0);
        wes = 0; done2 = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (dm_we) wes++;
            if (done) done2++;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (dm_we) wes++;
            if (done) done2++;
        end
        chk("arst_no_write", wes,   0);
        chk("arst_no_done",  done2, 0);
        run(1'b0, 1'b0, 10'h018, 32'h0, 1'b0);
        chk("arst_done_cyc", done_cyc, 3);
        chk("arst_mem", rdata, 32'h55667788);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
